// File: rtl/mem_if_pkg.sv
// Shared types and constants for the memory_request/memory_response handshake.
package mem_if_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RESPOND = 2'd2,
        RELEASE = 2'd3
    } state_e;

    localparam logic MODE_READ  = 1'b0;
    localparam logic MODE_WRITE = 1'b1;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 16;

endpackage

// File: rtl/memory_responder_if.sv
// Handshake bus between an initiator (ROM loader / CPU) and the memory responder.
interface memory_responder_if
    import mem_if_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
);
    logic              memory_request;
    logic              memory_mode;
    logic [ADDR_W-1:0] locator_bus;
    logic [DATA_W-1:0] write_bus;
    logic [DATA_W-1:0] read_bus;
    logic              memory_response;
    logic              busy;
    logic              addr_error;

    modport master (
        output memory_request, memory_mode, locator_bus, write_bus,
        input  read_bus, memory_response, busy, addr_error
    );

    modport slave (
        input  memory_request, memory_mode, locator_bus, write_bus,
        output read_bus, memory_response, busy, addr_error
    );
endinterface

// File: rtl/memory_array.sv
// Single-port synchronous RAM with registered read (read-before-write).
module memory_array #(
  parameter int    DATA_W    = 16,
  parameter int    DEPTH     = 65536,
  parameter string INIT_FILE = "",
  localparam int   AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Write on we; the read port always samples the presented address.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/memory_responder.sv
// Memory responder: accepts one access per handshake, performs it after
// LATENCY cycles and signals completion with a one-cycle response pulse.
module memory_responder
    import mem_if_pkg::*;
#(
    parameter int    DATA_W    = DEF_DATA_W,
    parameter int    ADDR_W    = DEF_ADDR_W,
    parameter int    DEPTH     = 65536,
    parameter int    LATENCY   = 2,
    parameter string INIT_FILE = ""
) (
    input  logic             clk,
    input  logic             rst_n,
    memory_responder_if.slave bus
);
    localparam int              AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]      CNT_INIT = 4'(LATENCY - 1);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              mode_q, mode_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              resp_q, resp_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;

    logic              in_range;
    logic              commit;
    logic              ram_we;
    logic [AW-1:0]     ram_addr;
    logic [DATA_W-1:0] ram_rdata;

    assign in_range = ({1'b0, addr_q} < DEPTH_L);
    assign commit   = (state_q == BUSY) && (cnt_q == 4'd0);
    // A reset sampled on the commit edge abandons the write.
    assign ram_we   = rst_n && commit && (mode_q == MODE_WRITE) && in_range;
    // Present the incoming address while idle so the registered read data is
    // already valid for the latched address by the commit edge, even at LATENCY=1.
    assign ram_addr = (state_q == IDLE) ? bus.locator_bus[AW-1:0] : addr_q[AW-1:0];

    memory_array #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .INIT_FILE(INIT_FILE)
    ) u_array (
        .clk  (clk),
        .we   (ram_we),
        .addr (ram_addr),
        .wdata(wdata_q),
        .rdata(ram_rdata)
    );

    // Next-state and registered-output computation for the handshake FSM.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        resp_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.memory_request) begin
                    mode_d  = bus.memory_mode;
                    addr_d  = bus.locator_bus;
                    wdata_d = bus.write_bus;
                    cnt_d   = CNT_INIT;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    resp_d  = 1'b1;
                    err_d   = ~in_range;
                    if (mode_q == MODE_READ) begin
                        rdata_d = in_range ? ram_rdata : '0;
                    end
                    state_d = RESPOND;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESPOND: state_d = RELEASE;
            RELEASE: begin
                if (!bus.memory_request) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers; array contents survive reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            mode_q  <= MODE_READ;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            resp_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            resp_q  <= resp_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign bus.read_bus        = rdata_q;
    assign bus.memory_response = resp_q;
    assign bus.busy            = busy_q;
    assign bus.addr_error      = err_q;
endmodule

// File: tb/tb_memory_responder.sv
// Bench for memory_responder: two instances (DEPTH=256/LATENCY=2 and
// DEPTH=65536/LATENCY=4) checked every cycle against a cycle-count model.
module tb_memory_responder;
    import mem_if_pkg::*;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic        req  [2];
    logic        mode [2];
    logic        rstn [2];
    logic [15:0] loc  [2];
    logic [15:0] wd   [2];
    logic [15:0] rb   [2];
    logic        resp [2];
    logic        bsy  [2];
    logic        aerr [2];

    memory_responder_if #(.DATA_W(16), .ADDR_W(16)) if0 ();
    memory_responder_if #(.DATA_W(16), .ADDR_W(16)) if1 ();

    assign if0.memory_request = req[0];
    assign if0.memory_mode    = mode[0];
    assign if0.locator_bus    = loc[0];
    assign if0.write_bus      = wd[0];
    assign rb[0]   = if0.read_bus;
    assign resp[0] = if0.memory_response;
    assign bsy[0]  = if0.busy;
    assign aerr[0] = if0.addr_error;

    assign if1.memory_request = req[1];
    assign if1.memory_mode    = mode[1];
    assign if1.locator_bus    = loc[1];
    assign if1.write_bus      = wd[1];
    assign rb[1]   = if1.read_bus;
    assign resp[1] = if1.memory_response;
    assign bsy[1]  = if1.busy;
    assign aerr[1] = if1.addr_error;

    memory_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .LATENCY(2), .INIT_FILE(""))
        u_dut0 (.clk(clk), .rst_n(rstn[0]), .bus(if0.slave));
    memory_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH(65536), .LATENCY(4), .INIT_FILE(""))
        u_dut1 (.clk(clk), .rst_n(rstn[1]), .bus(if1.slave));

    function automatic int lat_of(int g);
        return (g == 0) ? 2 : 4;
    endfunction

    function automatic int depth_of(int g);
        return (g == 0) ? 256 : 65536;
    endfunction

    // Model state: a transaction accepted at edge acc completes at edge acc+LAT;
    // from edge acc+LAT+2 on, a sampled low request frees the responder.
    int          cyc;
    bit          mvalid  [2];
    bit          idle_m  [2];
    int          acc_m   [2];
    logic        cap_m   [2];
    logic [15:0] cap_a   [2];
    logic [15:0] cap_d   [2];
    logic        exp_resp[2];
    logic        exp_err [2];
    logic [15:0] rd_m    [2];
    logic [15:0] mem_m   [int];
    int          rsp_cnt [2];

    int n_chk;
    int n_fail;

    task automatic chk(string nm, int g, logic [15:0] act, logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %h expected %h (cycle %0d)", nm, g, act, exp, cyc);
        end
    endtask

    task automatic wait_resp(int g);
        int k;
        k = 0;
        while (resp[g] !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("resp_seen", g, 16'(resp[g]), 16'h1);
    endtask

    task automatic wait_idle(int g);
        int k;
        k = 0;
        while (bsy[g] !== 1'b0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("back_to_idle", g, 16'(bsy[g]), 16'h0);
    endtask

    // One handshake; inputs are scrambled after acceptance to show they are ignored.
    task automatic txn(input int g, input logic m, input logic [15:0] a, input logic [15:0] d,
                       input int hold, input bit early,
                       output logic [15:0] rdv, output logic errv);
        @(negedge clk);
        req[g] = 1'b1; mode[g] = m; loc[g] = a; wd[g] = d;
        @(negedge clk);
        mode[g] = ~m; loc[g] = ~a; wd[g] = ~d;
        if (early) req[g] = 1'b0;
        wait_resp(g);
        rdv  = rb[g];
        errv = aerr[g];
        repeat (hold) @(negedge clk);
        if (hold > 0) chk("busy_while_held", g, 16'(bsy[g]), 16'h1);
        req[g] = 1'b0;
        wait_idle(g);
    endtask

    logic [15:0] burst_d [7];
    logic [15:0] rv;
    logic        ev;
    int          r;
    int          c0;

    initial begin
        burst_d = '{16'h2000, 16'h0006, 16'hADD0, 16'h0000, 16'hBBBB, 16'h0002, 16'h0001};
        n_chk = 0; n_fail = 0; cyc = 0;
        for (int g = 0; g < 2; g++) begin
            rstn[g] = 1'b0; req[g] = 1'b0; mode[g] = MODE_READ; loc[g] = '0; wd[g] = '0;
            rsp_cnt[g] = 0; idle_m[g] = 1'b1; rd_m[g] = '0;
        end

        fork
            // Behavioural model, evaluated on each active edge.
            forever begin
                @(posedge clk);
                cyc = cyc + 1;
                for (int g = 0; g < 2; g++) begin
                    exp_resp[g] = 1'b0;
                    exp_err[g]  = 1'b0;
                    if (!rstn[g]) begin
                        mvalid[g] = 1'b1;
                        idle_m[g] = 1'b1;
                        rd_m[g]   = '0;
                    end else if (idle_m[g]) begin
                        if (req[g]) begin
                            idle_m[g] = 1'b0;
                            acc_m[g]  = cyc;
                            cap_m[g]  = mode[g];
                            cap_a[g]  = loc[g];
                            cap_d[g]  = wd[g];
                        end
                    end else if (cyc == acc_m[g] + lat_of(g)) begin
                        exp_resp[g] = 1'b1;
                        exp_err[g]  = (int'(cap_a[g]) >= depth_of(g));
                        if (cap_m[g] == MODE_WRITE) begin
                            if (!exp_err[g]) mem_m[g * 65536 + int'(cap_a[g])] = cap_d[g];
                        end else if (exp_err[g]) begin
                            rd_m[g] = '0;
                        end else begin
                            rd_m[g] = mem_m.exists(g * 65536 + int'(cap_a[g])) ?
                                      mem_m[g * 65536 + int'(cap_a[g])] : 16'h0000;
                        end
                    end else if (cyc >= acc_m[g] + lat_of(g) + 2 && !req[g]) begin
                        idle_m[g] = 1'b1;
                    end
                end
            end
            // Per-cycle compare of every output against the model.
            forever begin
                @(negedge clk);
                for (int g = 0; g < 2; g++) begin
                    if (mvalid[g]) begin
                        chk("memory_response", g, 16'(resp[g]), 16'(exp_resp[g]));
                        chk("busy", g, 16'(bsy[g]), 16'(!idle_m[g]));
                        chk("addr_error", g, 16'(aerr[g]), 16'(exp_err[g]));
                        chk("read_bus", g, rb[g], rd_m[g]);
                        if (resp[g] === 1'b1) rsp_cnt[g]++;
                    end
                end
            end
        join_none

        // Reset with request already high: nothing happens until release.
        req[0] = 1'b1; mode[0] = MODE_WRITE; loc[0] = 16'h0010; wd[0] = 16'hBEEF;
        repeat (3) @(negedge clk);
        chk("reset_resp", 0, 16'(resp[0]), 16'h0);
        chk("reset_busy", 0, 16'(bsy[0]), 16'h0);
        chk("reset_read_bus", 0, rb[0], 16'h0000);
        chk("reset_read_bus", 1, rb[1], 16'h0000);
        rstn[0] = 1'b1; rstn[1] = 1'b1; r = cyc;
        @(negedge clk);
        chk("busy_first_cycle", 0, 16'(bsy[0]), 16'h1);
        wait_resp(0);
        chk("accept_to_resp_edges", 0, 16'(cyc - r), 16'd3);
        req[0] = 1'b0;
        wait_idle(0);

        // Read back the write of 0xBEEF.
        txn(0, MODE_READ, 16'h0010, 16'h0000, 0, 1'b0, rv, ev);
        chk("readback_beef", 0, rv, 16'hBEEF);

        // Loader-style burst then readback.
        c0 = rsp_cnt[0];
        for (int i = 0; i < 7; i++) txn(0, MODE_WRITE, 16'(i), burst_d[i], 0, 1'b0, rv, ev);
        chk("burst_resp_count", 0, 16'(rsp_cnt[0] - c0), 16'd7);
        for (int i = 0; i < 7; i++) begin
            txn(0, MODE_READ, 16'(i), 16'h0000, 0, 1'b0, rv, ev);
            chk("burst_readback", 0, rv, burst_d[i]);
        end

        // Request held ten cycles past the response: still one access.
        c0 = rsp_cnt[0];
        txn(0, MODE_WRITE, 16'h0020, 16'h4242, 10, 1'b0, rv, ev);
        chk("held_resp_count", 0, 16'(rsp_cnt[0] - c0), 16'd1);
        txn(0, MODE_READ, 16'h0020, 16'h0000, 0, 1'b0, rv, ev);
        chk("held_readback", 0, rv, 16'h4242);

        // Out of range on the 256-word instance.
        txn(0, MODE_WRITE, 16'h0100, 16'h1234, 0, 1'b0, rv, ev);
        chk("oor_write_err", 0, 16'(ev), 16'h1);
        txn(0, MODE_READ, 16'h0000, 16'h0000, 0, 1'b0, rv, ev);
        chk("alias_unchanged", 0, rv, 16'h2000);
        chk("inrange_err", 0, 16'(ev), 16'h0);
        txn(0, MODE_READ, 16'h0100, 16'h0000, 0, 1'b0, rv, ev);
        chk("oor_read_data", 0, rv, 16'h0000);
        chk("oor_read_err", 0, 16'(ev), 16'h1);

        // LATENCY=4 instance: establish a prior value.
        txn(1, MODE_WRITE, 16'h0020, 16'h1111, 0, 1'b0, rv, ev);
        txn(1, MODE_READ, 16'h0020, 16'h0000, 0, 1'b0, rv, ev);
        chk("lat4_readback", 1, rv, 16'h1111);

        // Reset during BUSY abandons the write and suppresses the response.
        c0 = rsp_cnt[1];
        @(negedge clk);
        req[1] = 1'b1; mode[1] = MODE_WRITE; loc[1] = 16'h0020; wd[1] = 16'h5555;
        repeat (2) @(negedge clk);
        chk("busy_before_reset", 1, 16'(bsy[1]), 16'h1);
        rstn[1] = 1'b0; req[1] = 1'b0;
        repeat (2) @(negedge clk);
        rstn[1] = 1'b1;
        repeat (6) @(negedge clk);
        chk("reset_abort_no_resp", 1, 16'(rsp_cnt[1] - c0), 16'd0);
        txn(1, MODE_READ, 16'h0020, 16'h0000, 0, 1'b0, rv, ev);
        chk("reset_abort_prior", 1, rv, 16'h1111);

        // Request dropped during BUSY: access still completes.
        txn(1, MODE_WRITE, 16'h0030, 16'h7777, 0, 1'b1, rv, ev);
        txn(1, MODE_READ, 16'h0030, 16'h0000, 0, 1'b0, rv, ev);
        chk("early_drop_readback", 1, rv, 16'h7777);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
